// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command master: FSM states, FIFO entry
// layout and the command-byte codes understood by the slave's decoder.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    BIT_HI = 3'd2,
    BIT_LO = 3'd3,
    WAIT   = 3'd4,
    HOLD   = 3'd5,
    GAP    = 3'd6
  } state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;

  localparam logic [7:0] CMD_NOP        = 8'h00;
  localparam logic [7:0] CMD_WR_REG     = 8'h01;
  localparam logic [7:0] CMD_WR_SPRITE  = 8'h02;
  localparam logic [7:0] CMD_RD_SPRITE  = 8'h03;
  localparam logic [7:0] CMD_SET_COLOUR = 8'h04;

  // Chip select is asserted in every state between SETUP and HOLD inclusive.
  function automatic logic cs_active(input state_t s);
    case (s)
      SETUP, BIT_HI, BIT_LO, WAIT, HOLD: cs_active = 1'b1;
      default:                           cs_active = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_cmd_master_cmd_fifo.sv
// Synchronous show-ahead FIFO of {last, data} command entries with registered
// full/empty flags; count_next exposes the occupancy after the current cycle.
module cmd_fifo
  import spi_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  entry_t      wr_entry,
  input  logic        pop,
  output entry_t      rd_entry,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count_next
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);

  entry_t        mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_r, empty_r, push_s, pop_s;

  assign push_s   = push && !full_r;
  assign pop_s    = pop && !empty_r;
  assign rd_entry = mem_r[rd_ptr_r];
  assign full     = full_r;
  assign empty    = empty_r;

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    count_next = count_r;
    if (push_s && !pop_s) begin
      count_next = count_r + CNT_ONE;
    end else if (pop_s && !push_s) begin
      count_next = count_r - CNT_ONE;
    end else begin
      count_next = count_r;
    end
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_next;
      full_r  <= (count_next == CNT_FULL);
      empty_r <= (count_next == CNT_ZERO);
    end
  end

  // Entry storage; a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_entry;
  end

endmodule

// File: rtl/spi_cmd_master.sv
// SPI master (CPOL=0, CPHA=1, MSB first) serialising queued command bytes and capturing MISO.
// Define SPI_CMD_MASTER_FRAME_GATE_EN to start transactions only on a next_frame pulse.
module spi_cmd_master
  import spi_cmd_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       next_frame,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  localparam int         AW     = $clog2(FIFO_DEPTH);
  localparam logic [7:0] H_LAST = 8'(CLK_DIV - 1);

  state_t      state_r, state_nxt_s;
  logic [7:0]  cnt_r, tx_r, rx_sh_r, rx_data_r;
  logic [2:0]  bit_r;
  logic        last_r, cs_r, sclk_r, mosi_r, rx_valid_r, busy_r;
  logic        pop_s, tdone_s, gate_s, full_s, empty_s, hi_entry_s, lo_entry_s;
  logic [AW:0] fifo_cnt_nxt_s;
  entry_t      wr_entry_s, rd_entry_s;

`ifdef SPI_CMD_MASTER_FRAME_GATE_EN
  assign gate_s = next_frame;
`else
  logic unused_next_frame_s;
  assign unused_next_frame_s = next_frame;
  assign gate_s              = 1'b1;
`endif

  assign wr_entry_s = {in_last, in_data};
  assign tdone_s    = (cnt_r == H_LAST);
  assign hi_entry_s = (state_nxt_s == BIT_HI) && (state_r != BIT_HI);
  assign lo_entry_s = (state_nxt_s == BIT_LO) && (state_r == BIT_HI);

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (in_valid),
    .wr_entry   (wr_entry_s),
    .pop        (pop_s),
    .rd_entry   (rd_entry_s),
    .full       (full_s),
    .empty      (empty_s),
    .count_next (fifo_cnt_nxt_s)
  );

  // Next-state and FIFO pop decision.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && gate_s) begin
          pop_s       = 1'b1;
          state_nxt_s = SETUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP:  state_nxt_s = tdone_s ? BIT_HI : SETUP;
      BIT_HI: state_nxt_s = tdone_s ? BIT_LO : BIT_HI;
      BIT_LO: begin
        if (!tdone_s) begin
          state_nxt_s = BIT_LO;
        end else if (bit_r != 3'd7) begin
          state_nxt_s = BIT_HI;
        end else if (last_r) begin
          state_nxt_s = HOLD;
        end else if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = BIT_HI;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      WAIT: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = BIT_HI;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      HOLD:    state_nxt_s = tdone_s ? GAP : HOLD;
      GAP:     state_nxt_s = tdone_s ? IDLE : GAP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, timer, shift registers and registered pin/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      tx_r       <= 8'd0;
      rx_sh_r    <= 8'd0;
      rx_data_r  <= 8'd0;
      bit_r      <= 3'd0;
      last_r     <= 1'b0;
      cs_r       <= 1'b1;
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      rx_valid_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) begin
        cnt_r <= 8'd0;
      end else if (!tdone_s) begin
        cnt_r <= cnt_r + 8'd1;
      end
      if (pop_s) last_r <= rd_entry_s.last;
      // A pop straight into BIT_HI drives the new byte's MSB on the same edge.
      if (hi_entry_s) begin
        if (pop_s) begin
          mosi_r <= rd_entry_s.data[7];
          tx_r   <= {rd_entry_s.data[6:0], 1'b0};
          bit_r  <= 3'd0;
        end else begin
          mosi_r <= tx_r[7];
          tx_r   <= {tx_r[6:0], 1'b0};
          bit_r  <= (state_r == SETUP) ? 3'd0 : bit_r + 3'd1;
        end
      end else if (pop_s) begin
        tx_r <= rd_entry_s.data;
      end
      rx_valid_r <= 1'b0;
      if (lo_entry_s) begin
        rx_sh_r <= {rx_sh_r[6:0], spi_miso};
        if (bit_r == 3'd7) begin
          rx_data_r  <= {rx_sh_r[6:0], spi_miso};
          rx_valid_r <= 1'b1;
        end
      end
      cs_r   <= !cs_active(state_nxt_s);
      sclk_r <= (state_nxt_s == BIT_HI);
      busy_r <= (state_nxt_s != IDLE) || (fifo_cnt_nxt_s != (AW + 1)'(0));
    end
  end

  assign in_ready = !full_s;
  assign spi_cs   = cs_r;
  assign spi_sclk = sclk_r;
  assign spi_mosi = mosi_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Scoreboard bench for spi_cmd_master: a pin-level monitor decodes SPI bytes and
// rx pulses against queues filled at stimulus time; a slave model drives MISO.
module tb_spi_cmd_master;
  import spi_cmd_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int H          = CLK_DIV;
`ifdef SPI_CMD_MASTER_FRAME_GATE_EN
  localparam logic NF_DEFAULT = 1'b1;
`else
  localparam logic NF_DEFAULT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, in_valid, in_last, in_ready, next_frame;
  logic [7:0] in_data, rx_data;
  logic       spi_sclk, spi_mosi, spi_miso, spi_cs, rx_valid, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic       loop_mode = 1'b0;
  logic       slv_miso  = 1'b0;

  assign spi_miso = loop_mode ? spi_mosi : slv_miso;

  always #5 clk = ~clk;

  spi_cmd_master #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .next_frame (next_frame),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_cs     (spi_cs),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / slave model state.
  int         cyc = 0;
  logic       prev_cs = 1'b1, prev_sclk = 1'b0;
  int         cs_low_cnt = 0, cs_high_cnt = 0, win_rises = 0;
  int         last_win_len = 0, last_win_rises = 0, win_count = 0;
  int         rx_pulses = 0, last_rise_cyc = 0, mon_bits = 0, slv_bits = 0;
  logic [7:0] mon_byte = 8'd0, slv_byte = 8'd0;
  logic       seen_win = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_cs  = 1'b1;
      prev_sclk = 1'b0;
      mon_bits = 0;
      slv_bits = 0;
      win_rises = 0;
      cs_low_cnt = 0;
      seen_win = 1'b0;
    end else begin
      if (!prev_cs && spi_cs) begin
        last_win_len   = cs_low_cnt;
        last_win_rises = win_rises;
        win_count++;
        check("cs_release_on_byte_boundary", 32'(mon_bits), 32'd0);
        cs_high_cnt = 0;
        seen_win    = 1'b1;
        slv_bits    = 0;
      end
      if (prev_cs && !spi_cs) begin
        if (seen_win) check("cs_gap_min", 32'(cs_high_cnt >= H), 32'd1);
        cs_low_cnt = 0;
        win_rises  = 0;
        mon_bits   = 0;
      end
      if (spi_cs) begin
        cs_high_cnt++;
        check("sclk_low_while_cs_high", 32'(spi_sclk), 32'd0);
      end else begin
        cs_low_cnt++;
      end
      if (!prev_sclk && spi_sclk) begin
        if (win_rises % 8 != 0) check("sclk_period", 32'(cyc - last_rise_cyc), 32'(2 * H));
        last_rise_cyc = cyc;
        win_rises++;
        if (!loop_mode) begin
          if (slv_bits == 0) begin
            slv_byte = 8'($urandom);
            rx_exp_q.push_back(slv_byte);
          end
          slv_miso = slv_byte[7 - slv_bits];
          slv_bits = (slv_bits + 1) % 8;
        end
      end
      if (prev_sclk && !spi_sclk) begin
        mon_byte = {mon_byte[6:0], spi_mosi};
        mon_bits++;
        if (mon_bits == 8) begin
          mon_bits = 0;
          if (tx_exp_q.size() == 0) check("mosi_unexpected_byte", 32'(mon_byte), 32'hFFFF_FFFF);
          else check("mosi_byte", 32'(mon_byte), 32'(tx_exp_q.pop_front()));
        end
      end
      if (rx_valid) begin
        rx_pulses++;
        check("rx_valid_on_sclk_fall", 32'(prev_sclk && !spi_sclk), 32'd1);
        if (rx_exp_q.size() == 0) check("rx_unexpected_byte", 32'(rx_data), 32'hFFFF_FFFF);
        else check("rx_byte", 32'(rx_data), 32'(rx_exp_q.pop_front()));
      end
      prev_cs   = spi_cs;
      prev_sclk = spi_sclk;
    end
  end

  int burst_cnt = 0;
  int stall_at  = -1;

  task automatic push(input logic [7:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    if (!in_ready && stall_at < 0) stall_at = burst_cnt;
    while (!in_ready && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      check("push_accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(posedge clk); #1;
      burst_cnt++;
      tx_exp_q.push_back(d);
      if (loop_mode) rx_exp_q.push_back(d);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((busy || !spi_cs || tx_exp_q.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("idle_reached", 32'(t < budget), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int         w, p, t, nb;
    logic       low_seen;
    logic [7:0] cmds [5];
    cmds[0] = CMD_NOP; cmds[1] = CMD_WR_REG; cmds[2] = CMD_WR_SPRITE;
    cmds[3] = CMD_RD_SPRITE; cmds[4] = CMD_SET_COLOUR;

    reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_last = 1'b0; next_frame = NF_DEFAULT;
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(spi_cs), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: 0xA5, slave model on MISO.
    push(8'hA5, 1'b1);
    wait_idle(1000);
    check("single_cs_low_len", 32'(last_win_len), 32'(18 * H));
    check("single_sclk_rises", 32'(last_win_rises), 32'd8);
    repeat (H) @(negedge clk);
    check("single_cs_high_after", 32'(spi_cs), 32'd1);

    // Loopback: MISO tied to MOSI.
    loop_mode = 1'b1;
    p = rx_pulses;
    push(8'h3C, 1'b1);
    wait_idle(1000);
    check("loopback_rx_pulses", 32'(rx_pulses - p), 32'd1);
    check("loopback_rx_data_held", 32'(rx_data), 32'h3C);
    loop_mode = 1'b0;

    // Underrun: second byte arrives long after the first finished.
    w = win_count;
    push(8'h01, 1'b0);
    repeat (100) @(negedge clk);
    check("wait_cs_low", 32'(spi_cs), 32'd0);
    check("wait_sclk_low", 32'(spi_sclk), 32'd0);
    check("wait_busy", 32'(busy), 32'd1);
    push(8'h02, 1'b1);
    wait_idle(1000);
    check("underrun_single_window", 32'(win_count - w), 32'd1);
    check("underrun_window_rises", 32'(last_win_rises), 32'd16);

    // Backpressure: six bytes back-to-back.
    burst_cnt = 0;
    stall_at  = -1;
    for (int i = 0; i < 6; i++) push(8'h40 + 8'(i), (i == 5));
    check("backpressure_stall_after", 32'(stall_at), 32'd5);
    wait_idle(3000);
    check("backpressure_window_rises", 32'(last_win_rises), 32'd48);

    // Reset during bit 3.
    push(8'hC3, 1'b1);
    t = 0;
    while (win_rises < 4 && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    check("reached_bit3", 32'(win_rises >= 4), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_cs", 32'(spi_cs), 32'd1);
    check("midrst_sclk", 32'(spi_sclk), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    tx_exp_q.delete();
    rx_exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    push(8'h96, 1'b1);
    wait_idle(1000);
    check("post_reset_cs_low_len", 32'(last_win_len), 32'(18 * H));

    // Randomised transactions with random inter-byte gaps (some underrun).
    for (int tr = 0; tr < 20; tr++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 60)) @(negedge clk);
        push((b == 0) ? cmds[$urandom_range(0, 4)] : 8'($urandom), (b == nb - 1));
      end
      if ($urandom_range(0, 1) == 1) wait_idle(5000);
    end
    wait_idle(8000);

`ifdef SPI_CMD_MASTER_FRAME_GATE_EN
    // Frame gate: nothing starts until next_frame.
    next_frame = 1'b0;
    push(8'h10, 1'b1);
    low_seen = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (!spi_cs) low_seen = 1'b1;
    end
    check("gate_cs_held_high", 32'(low_seen), 32'd0);
    next_frame = 1'b1;
    @(negedge clk);
    next_frame = 1'b0;
    check("gate_cs_fall_next_cycle", 32'(spi_cs), 32'd0);
    wait_idle(1000);
    next_frame = NF_DEFAULT;
`else
    low_seen = 1'b0;
`endif

    check("tx_queue_drained", 32'(tx_exp_q.size()), 32'd0);
    check("rx_queue_drained", 32'(rx_exp_q.size()), 32'd0);
    check("end_idle_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run exceeded time limit, got %0d errors so far, expected completion", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
- SPI master that drives the sprite/pony chip's SPI slave port (spi_sclk, spi_mosi, spi_cs) from a byte stream.
- Sits directly upstream of the display top on the FPGA/test-harness side.
- Queues {last, byte} entries from a valid/ready source in a small FIFO.
- Serialises in mode CPOL=0, CPHA=1, MSB first, CS active low, slow enough for the slave's clk-domain synchroniser.
- Captures MISO bytes for sprite read-back.

Parameters:
- CLK_DIV, 4, SCLK half-period in clk cycles; legal 2..255.
- FIFO_DEPTH, 4, command FIFO entries; power of two, >=2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  command byte valid
- in_data  in  8  command/payload byte
- in_last  in  1  byte ends the transaction (CS released after it)
- in_ready  out  1  FIFO can accept; equals !full
- next_frame  in  1  frame-start pulse from the display top (used only with the optional feature)
- spi_sclk  out  1  SPI clock, idle low
- spi_mosi  out  1  SPI data to slave
- spi_miso  in  1  SPI data from slave
- spi_cs  out  1  chip select, active low, idle high
- rx_data  out  8  last byte received on MISO
- rx_valid  out  1  one-cycle pulse when rx_data updates
- busy  out  1  high while not IDLE or FIFO non-empty

Behaviour:
- Reset (async, active-high), all outputs immediately:
  - spi_cs=1, spi_sclk=0, spi_mosi=0
  - rx_data=0, rx_valid=0, busy=0, in_ready=1
  - FIFO emptied; state=IDLE
- Reset mid-transfer aborts the transfer with no partial byte flushed.
- All outputs are registered (no combinational path from inputs to SPI pins).
- FIFO:
  - Push when in_valid && in_ready.
  - Push while full is ignored (in_ready=0).
  - Simultaneous push and pop is legal at any non-full occupancy.
- Half-period timer H = CLK_DIV cycles.
- IDLE:
  - cs=1, sclk=0.
  - FIFO non-empty (and gate open, see optional feature) -> pop -> SETUP.
- SETUP: cs=0 for H cycles -> BIT_HI.
- BIT_HI:
  - Entry cycle: sclk rises and mosi = current bit (MSB first).
  - Hold H cycles -> BIT_LO.
- BIT_LO:
  - Entry cycle: sclk falls (slave samples on this edge); master samples spi_miso into the rx shift register on the same cycle.
  - Hold H cycles.
  - After the 8th bit:
    - rx_valid pulses for 1 cycle and rx_data is loaded.
    - last=1 -> HOLD.
    - last=0 and FIFO non-empty -> pop, BIT_HI (no gap).
    - last=0 and FIFO empty -> WAIT.
  - Otherwise -> BIT_HI with the next bit.
- WAIT: cs=0, sclk=0, mosi held; on FIFO non-empty -> pop -> BIT_HI.
- HOLD: cs=0 for H cycles -> GAP with cs=1.
- GAP: cs=1 for H cycles -> IDLE. Enforces minimum CS-high time.
- Byte time = 16*H cycles.
- Single-byte transaction: cs low for exactly (2+16)*H cycles.
- mosi keeps its last driven value outside BIT states.

Optional Feature:
- Macro SPI_CMD_MASTER_FRAME_GATE_EN.
- Defined:
  - IDLE leaves only on the cycle after a next_frame pulse while the FIFO is non-empty.
  - A next_frame seen with an empty FIFO is forgotten.
  - Once started, the transaction runs to in_last regardless of further pulses.
  - Result: colour/sprite updates land in blanking.
- Undefined: next_frame is ignored and IDLE leaves as soon as the FIFO is non-empty.

Decomposition:
- Package spi_cmd_pkg holds:
  - state enum {IDLE, SETUP, BIT_HI, BIT_LO, WAIT, HOLD, GAP}
  - the {last, data} entry struct
  - SPI command-byte constants shared with the slave's decoder
- One sub-module: cmd_fifo (synchronous FIFO of the entry struct, full/empty flags, async active-high reset).

Test Plan:
- Single byte, CLK_DIV=4:
  - Stimulus: push 0xA5 with last=1.
  - Expect: cs low for exactly 72 cycles; 8 sclk rising edges spaced 8 cycles apart; mosi at each falling edge = 1,0,1,0,0,1,0,1; then cs high for at least 4 cycles.
- Loopback:
  - Stimulus: tie miso=mosi, send 0x3C with last=1.
  - Expect: exactly one rx_valid pulse, rx_data=0x3C on the cycle of the 8th falling edge.
- Multi-byte with underrun:
  - Stimulus: push 0x01 (last=0), then 0x02 (last=1) 100 cycles later.
  - Expect: cs stays low throughout; sclk low during WAIT; a single cs-low window.
- Backpressure, FIFO_DEPTH=4:
  - Stimulus: push 6 bytes back-to-back.
  - Expect: in_ready drops after 5 accepted (1 popped plus 4 queued); all bytes appear on mosi in order, none lost.
- Reset mid-transfer:
  - Stimulus: assert reset during bit 3.
  - Expect: same cycle cs=1, sclk=0, busy=0; after release, a new byte transmits cleanly.
- Frame gate (SPI_CMD_MASTER_FRAME_GATE_EN defined):
  - Stimulus: push 0x10 with last=1, no next_frame.
  - Expect: cs stays high for 1000 cycles; after a next_frame pulse, cs falls on the following cycle.
